// File: rtl/uart_pkg.sv
// Shared UART constants: receive-path baud divisors and a width helper.
package uart_pkg;

  localparam int unsigned CLK_HZ      = 50_000_000;
  localparam int unsigned BAUD_RATE   = 115_200;
  localparam int unsigned OVERSAMPLE  = 16;
  localparam int unsigned BAUD_DIV    = CLK_HZ / BAUD_RATE;
  localparam int unsigned BAUD_DIV_OS = CLK_HZ / (BAUD_RATE * OVERSAMPLE);

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Byte storage for the receive FIFO: one synchronous write port, one asynchronous read port.
module fifo_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: show-ahead byte queue with level, full/empty, sticky overrun and level irq.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned THRESH = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    rcv,
  input  logic [7:0]              rx_data,
  input  logic                    rd,
  input  logic                    ovr_clr,
  output logic [7:0]              rd_data,
  output logic                    empty,
  output logic                    full,
  output logic [clog2(DEPTH):0]   level,
  output logic                    overrun,
  output logic                    irq
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL   = DEPTH[AW:0];
  localparam logic [AW:0] LVL_THRESH = THRESH[AW:0];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    ram_q;
  logic [7:0]    last_byte;
  logic          wr_en;
  logic          rd_en;
  logic          drop;

  assign empty = (level == '0);
  assign full  = (level == LVL_FULL);
  assign irq   = (level >= LVL_THRESH);

  // A read frees a slot in the same cycle, so a full FIFO still accepts rcv alongside rd.
  assign rd_en = rd & ~empty;
  assign wr_en = rcv & (~full | rd);
  assign drop  = rcv & full & ~rd;

  fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (rx_data),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  // When empty the slot at rd_ptr is stale, so the last popped byte is shown instead.
  assign rd_data = empty ? last_byte : ram_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overrun   <= 1'b0;
      last_byte <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_byte <= ram_q;
      end
      unique case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop)         overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: stored bytes are queued as they are sent and checked as they are popped.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rcv;
  logic [7:0] rx_data;
  logic       rd;
  logic       ovr_clr;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] level;
  logic       overrun;
  logic       irq;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(
    .DEPTH  (16),
    .THRESH (1)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .rcv     (rcv),
    .rx_data (rx_data),
    .rd      (rd),
    .ovr_clr (ovr_clr),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .level   (level),
    .overrun (overrun),
    .irq     (irq)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must show the oldest queued byte.
  always @(negedge clk) begin
    if (rstn === 1'b1 && rd === 1'b1 && empty === 1'b0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got 0x%0h expected no data", rd_data);
      end else begin
        chk("pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // One cycle of stimulus; push marks a byte the FIFO is expected to keep.
  task automatic op(input logic r, input logic [7:0] d, input logic p, input logic c,
                    input logic push);
    rcv = r; rx_data = d; rd = p; ovr_clr = c;
    if (push) exp_q.push_back(d);
    @(posedge clk);
    #1;
    rcv = 1'b0; rx_data = 8'h00; rd = 1'b0; ovr_clr = 1'b0;
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 16; i++) op(1'b1, base + 8'(i), 1'b0, 1'b0, 1'b1);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rstn = 1'b0; rcv = 1'b0; rx_data = 8'h00; rd = 1'b0; ovr_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    chk("rst_empty",   32'(empty),   32'd1);
    chk("rst_full",    32'(full),    32'd0);
    chk("rst_level",   32'(level),   32'd0);
    chk("rst_irq",     32'(irq),     32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'h00);

    // first byte shows ahead on the next cycle
    op(1'b1, 8'h41, 1'b0, 1'b0, 1'b1);
    chk("w1_empty", 32'(empty),   32'd0);
    chk("w1_level", 32'(level),   32'd1);
    chk("w1_data",  32'(rd_data), 32'h41);
    chk("w1_irq",   32'(irq),     32'd1);
    drain(1);
    chk("r1_empty", 32'(empty),   32'd1);
    chk("r1_irq",   32'(irq),     32'd0);
    chk("r1_hold",  32'(rd_data), 32'h41);

    // fill to full, drain in order
    for (int i = 0; i < 16; i++) begin
      op(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
      if (i == 14) chk("fill15_full", 32'(full), 32'd0);
    end
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_level", 32'(level), 32'd16);
    drain(16);
    chk("drain_empty", 32'(empty),   32'd1);
    chk("drain_hold",  32'(rd_data), 32'h0F);

    // overrun: dropped byte, clear, clear coinciding with a new drop
    fill(8'h10);
    op(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    chk("ovr_set",   32'(overrun), 32'd1);
    chk("ovr_level", 32'(level),   32'd16);
    op(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("ovr_clr", 32'(overrun), 32'd0);
    op(1'b1, 8'hAB, 1'b0, 1'b1, 1'b0);
    chk("ovr_clr_vs_drop", 32'(overrun), 32'd1);
    op(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("ovr_clr2", 32'(overrun), 32'd0);
    drain(16);
    chk("ovr_drain_empty", 32'(empty), 32'd1);

    // rcv and rd together while full
    fill(8'h20);
    op(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
    chk("fullrw_level",   32'(level),   32'd16);
    chk("fullrw_overrun", 32'(overrun), 32'd0);
    chk("fullrw_full",    32'(full),    32'd1);
    drain(16);
    chk("fullrw_last", 32'(rd_data), 32'h55);
    chk("fullrw_empty", 32'(empty),  32'd1);

    // rd on empty ignored; rcv+rd on empty stores; rcv+rd mid-level keeps level
    op(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("rd_empty_level", 32'(level),   32'd0);
    chk("rd_empty_data",  32'(rd_data), 32'h55);
    op(1'b1, 8'h33, 1'b1, 1'b0, 1'b1);
    chk("emptyrw_level", 32'(level),   32'd1);
    chk("emptyrw_data",  32'(rd_data), 32'h33);
    op(1'b1, 8'h34, 1'b0, 1'b0, 1'b1);
    op(1'b1, 8'h35, 1'b1, 1'b0, 1'b1);
    chk("midrw_level", 32'(level),   32'd2);
    chk("midrw_data",  32'(rd_data), 32'h34);
    drain(2);

    // reset mid-operation with rcv asserted
    for (int i = 0; i < 5; i++) op(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
    chk("pre_rst_level", 32'(level), 32'd5);
    rstn = 1'b0;
    op(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
    chk("mrst_level",   32'(level),   32'd0);
    chk("mrst_empty",   32'(empty),   32'd1);
    chk("mrst_data",    32'(rd_data), 32'h00);
    chk("mrst_overrun", 32'(overrun), 32'd0);
    op(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("mrst_rd_level", 32'(level), 32'd0);

    repeat (2) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
